// File: rtl/mod_addsub_ctrl_pkg.sv
// mod_addsub_ctrl_pkg: shared widths, state encoding and op-mode constants
package mod_addsub_ctrl_pkg;
  localparam int WIDTH = 1027;
  localparam int AW = WIDTH + 1;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  typedef enum logic [2:0] {IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, FIN} state_t;
endpackage

// File: rtl/mod_addsub_ctrl.sv
// mod_addsub_ctrl: (A+B) mod M or (A-B) mod M using one or two external adder ops
module mod_addsub_ctrl
  import mod_addsub_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             add_start,
  output logic             add_subtract,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [AW-1:0]    add_result,
  input  logic             add_done
);
  state_t state, next;
  logic [WIDTH-1:0] m_q, t_q;
  logic sub_q;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? ISSUE1 : IDLE;
      ISSUE1:  next = WAIT1;
      WAIT1:   next = !add_done ? WAIT1 : (sub_q == OP_SUB && !add_result[WIDTH]) ? FIN : ISSUE2;
      ISSUE2:  next = WAIT2;
      WAIT2:   next = add_done ? FIN : WAIT2;
      default: next = IDLE;
    endcase
  end
  assign busy = state != IDLE;
  assign done = state == FIN;
  assign add_start = state == ISSUE1 || state == ISSUE2;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      m_q <= '0;
      t_q <= '0;
      sub_q <= 1'b0;
      result <= '0;
      add_a <= '0;
      add_b <= '0;
      add_subtract <= 1'b0;
    end else begin
      state <= next;
      if (state == IDLE && start) begin
        add_a <= in_a;
        add_b <= in_b;
        add_subtract <= subtract;
        sub_q <= subtract;
        m_q <= in_m;
      end
      // second op is always "T minus M" for add and "T plus M" for negative sub
      if (state == WAIT1 && add_done) begin
        t_q <= add_result[WIDTH-1:0];
        add_a <= add_result[WIDTH-1:0];
        add_b <= m_q;
        add_subtract <= sub_q == OP_ADD;
        if (next == FIN) result <= add_result[WIDTH-1:0];
      end
      if (state == WAIT2 && add_done)
        result <= (sub_q == OP_ADD && add_result[WIDTH]) ? t_q : add_result[WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// tb_mod_addsub_ctrl: directed vectors against a behavioural multi-cycle adder
module tb_mod_addsub_ctrl;
  import mod_addsub_ctrl_pkg::*;
  logic clk = 0, reset = 1, start = 0, subtract = 0;
  logic [WIDTH-1:0] in_a = '0, in_b = '0, in_m = '0;
  logic [WIDTH-1:0] result, add_a, add_b;
  logic done, busy, add_start, add_subtract, add_done;
  logic [AW-1:0] add_result;
  int tests = 0, fails = 0;
  int starts = 0, dones = 0, clash = 0, cyc = 0, ad_cyc = 0;
  logic last_sub;
  logic [WIDTH-1:0] last_b, big;
  logic [2:0] cnt;

  mod_addsub_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .subtract(subtract),
    .in_a(in_a), .in_b(in_b), .in_m(in_m), .result(result), .done(done), .busy(busy),
    .add_start(add_start), .add_subtract(add_subtract), .add_a(add_a), .add_b(add_b),
    .add_result(add_result), .add_done(add_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // external adder: fixed 3-cycle latency, result held until the next op
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 0;
      add_done <= 0;
      add_result <= '0;
    end else begin
      add_done <= 0;
      if (add_start) begin
        add_result <= add_subtract ? {1'b0, add_a} - {1'b0, add_b} : {1'b0, add_a} + {1'b0, add_b};
        cnt <= 3;
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) add_done <= 1;
      end
    end
  end

  always @(negedge clk) begin
    if (add_start) begin
      starts++;
      last_sub = add_subtract;
      last_b = add_b;
    end
    if (done) dones++;
    if (add_done) ad_cyc = cyc;
    if (add_start && add_done) clash++;
  end

  task automatic check(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (low 64 bits)", tag, got[63:0], exp[63:0]);
    end
  endtask

  task automatic run(input string tag, input logic sub, input logic [WIDTH-1:0] a, b, m,
                     input logic [WIDTH-1:0] exp, input int exp_starts, input logic restart);
    bit seen = 0;
    @(negedge clk);
    starts = 0;
    dones = 0;
    subtract = sub; in_a = a; in_b = b; in_m = m; start = 1;
    @(negedge clk);
    start = 0;
    check({tag, "_busy"}, busy, 1);
    if (restart) begin
      repeat (2) @(negedge clk);
      in_a = 1; in_b = 2; subtract = 0; start = 1;
      @(negedge clk);
      start = 0;
    end
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_result"}, result, exp);
    check({tag, "_busy_at_done"}, busy, 1);
    check({tag, "_ovh_ok"}, (cyc - ad_cyc) >= 1 && (cyc - ad_cyc) <= 3, 1);
    if (exp_starts == 2) begin
      check({tag, "_op2_sub"}, last_sub, !sub);
      check({tag, "_op2_b"}, last_b, m);
    end
    repeat (8) @(negedge clk);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_starts"}, starts, exp_starts);
    check({tag, "_dones"}, dones, 1);
    check({tag, "_result_hold"}, result, exp);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_add_start", add_start, 0);
    check("rst_result", result, 0);
    check("rst_add_a", add_a, 0);
    reset = 0;
    run("add_5_7", OP_ADD, 5, 7, 11, 1, 2, 0);
    run("add_3_4", OP_ADD, 3, 4, 11, 7, 2, 0);
    run("sub_3_8", OP_SUB, 3, 8, 11, 6, 2, 0);
    run("sub_8_3", OP_SUB, 8, 3, 11, 5, 1, 1);
    big = '0;
    big[WIDTH-1] = 1'b1;
    big = big - 1;
    run("add_big", OP_ADD, big - 1, big - 1, big, big - 2, 2, 0);
    run("add_zero", OP_ADD, 0, 0, 11, 0, 2, 0);
    run("add_eq_m", OP_ADD, 4, 7, 11, 0, 2, 0);
    run("sub_eq", OP_SUB, 6, 6, 11, 0, 1, 0);
    @(negedge clk);
    dones = 0;
    subtract = OP_ADD; in_a = 5; in_b = 7; in_m = 11; start = 1;
    @(negedge clk);
    start = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_add_start", add_start, 0);
    check("midrst_done", done, 0);
    @(negedge clk);
    reset = 0;
    repeat (6) @(negedge clk);
    check("midrst_no_done", dones, 0);
    run("after_rst", OP_ADD, 1, 1, 11, 2, 2, 0);
    check("no_start_clash", clash, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
